dds_coeff_gen: RTL



---
 rtl/dds_pkg.sv | 59 +++++
 rtl/cordic_rot_step.sv | 36 +++
 rtl/dds_coeff_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants, state encoding and CORDIC arctangent table for the DDS
// coefficient generator.
package dds_pkg;

   localparam int DATA_W = 32;
   localparam int AMP_W  = 31;
   localparam int FRAC_W = 30;
   localparam int ATAN_N = 30;

   // CORDIC gain compensation 1/1.6468 in Q1.30; x starts here so no post-scale is needed.
   localparam logic [DATA_W-1:0] CORDIC_K = 32'h26DD_3B6A;

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      SCALE,
      DONE
   } state_t;

   // round(atan(2^-idx) * 2^32 / 2pi), binary angle where 2^32 is a full turn
   function automatic logic [DATA_W-1:0] atan_lut(input logic [4:0] idx);
      logic [DATA_W-1:0] a;
      case (idx)
         5'd0:    a = 32'h2000_0000;
         5'd1:    a = 32'h12E4_051E;
         5'd2:    a = 32'h09FB_385B;
         5'd3:    a = 32'h0511_11D4;
         5'd4:    a = 32'h028B_0D43;
         5'd5:    a = 32'h0145_D7E1;
         5'd6:    a = 32'h00A2_F61E;
         5'd7:    a = 32'h0051_7C55;
         5'd8:    a = 32'h0028_BE53;
         5'd9:    a = 32'h0014_5F2F;
         5'd10:   a = 32'h000A_2F98;
         5'd11:   a = 32'h0005_17CC;
         5'd12:   a = 32'h0002_8BE6;
         5'd13:   a = 32'h0001_45F3;
         5'd14:   a = 32'h0000_A2FA;
         5'd15:   a = 32'h0000_517D;
         5'd16:   a = 32'h0000_28BE;
         5'd17:   a = 32'h0000_145F;
         5'd18:   a = 32'h0000_0A30;
         5'd19:   a = 32'h0000_0518;
         5'd20:   a = 32'h0000_028C;
         5'd21:   a = 32'h0000_0146;
         5'd22:   a = 32'h0000_00A3;
         5'd23:   a = 32'h0000_0051;
         5'd24:   a = 32'h0000_0029;
         5'd25:   a = 32'h0000_0014;
         5'd26:   a = 32'h0000_000A;
         5'd27:   a = 32'h0000_0005;
         5'd28:   a = 32'h0000_0003;
         5'd29:   a = 32'h0000_0001;
         default: a = 32'h0000_0000;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation in rotation mode: drives z toward 0
// while rotating (x, y) by +/- atan(2^-i).
module cordic_rot_step
   import dds_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] z,
   input  logic [4:0]  i,
   output logic [31:0] x_n,
   output logic [31:0] y_n,
   output logic [31:0] z_n
);

   logic signed [31:0] x_sh;
   logic signed [31:0] y_sh;
   logic [31:0]        angle;

   assign x_sh  = $signed(x) >>> i;
   assign y_sh  = $signed(y) >>> i;
   assign angle = atan_lut(i);

   // NOTE: every output gets a value on every path so no latch is inferred.
   always_comb begin
      if (z[31]) begin
         x_n = x + y_sh;
         y_n = y - x_sh;
         z_n = z + angle;
      end else begin
         x_n = x - y_sh;
         y_n = y + x_sh;
         z_n = z - angle;
      end
   end

endmodule

// File: rtl/dds_coeff_gen.sv
// Iterative CORDIC that produces the amplitude-scaled sine and 2*cos
// coefficients for the recursive DDS oscillator, with cold-load/retune handshake.
module dds_coeff_gen
   import dds_pkg::*;
#(
   parameter int          ITER      = 24,
   parameter logic [31:0] PSTEP_MAX = 32'h3FFF_FFFF
)
(
   input  logic        Fg_CLK,
   input  logic        RESETn,
   input  logic        Start,
   input  logic [31:0] PhaseStep,
   input  logic [30:0] Amp,
   input  logic        Running,
   output logic [31:0] sinx,
   output logic [31:0] cos2x,
   output logic        Ready,
   output logic        FreqChng,
   output logic        Busy,
   output logic        RangeErr
);

   state_t state;
   state_t state_nxt;

   logic [31:0] x, y, z;
   logic [31:0] x_n, y_n, z_n;
   logic [4:0]  i;
   logic [30:0] amp_q;
   logic        pending;
   logic        go;

   logic signed [63:0] prod;
   logic [31:0]        scaled;
   logic               unused_prod;

   // A pending request is served from IDLE exactly like a fresh Start.
   assign go = (state == IDLE) && (Start || pending);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = ROT;
         ROT:     if (i == 5'(ITER - 1)) state_nxt = SCALE;
         SCALE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Ready    = (state == DONE) && !Running;
      FreqChng = (state == DONE) &&  Running;
      Busy     = (state != IDLE) || pending;
   end

   // Starts that arrive while busy (including in DONE) collapse into one rerun.
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn)                       pending <= 1'b0;
      else if (go)                       pending <= 1'b0;
      else if (Start && state != IDLE)   pending <= 1'b1;
   end

   cordic_rot_step u_step (
      .x   (x),
      .y   (y),
      .z   (z),
      .i   (i),
      .x_n (x_n),
      .y_n (y_n),
      .z_n (z_n)
   );

   // Q1.30 sine times Q1.30 amplitude is Q2.60; bits [61:30] bring it back to Q1.30.
   assign prod        = $signed(y) * $signed({1'b0, amp_q});
   assign scaled      = prod[61:30];
   assign unused_prod = ^{prod[63:62], prod[29:0]};

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         x        <= '0;
         y        <= '0;
         z        <= '0;
         i        <= '0;
         amp_q    <= '0;
         sinx     <= '0;
         cos2x    <= '0;
         RangeErr <= 1'b0;
      end else begin
         RangeErr <= 1'b0;
         if (go) begin
            amp_q <= Amp;
            x     <= CORDIC_K;
            y     <= '0;
            i     <= '0;
            if (PhaseStep > PSTEP_MAX) begin
               z        <= PSTEP_MAX;
               RangeErr <= 1'b1;
            end else begin
               z <= PhaseStep;
            end
         end else if (state == ROT) begin
            x <= x_n;
            y <= y_n;
            z <= z_n;
            i <= i + 5'd1;
         end else if (state == SCALE) begin
            // Loaded on the edge into DONE so the outputs change in the pulse cycle.
            sinx  <= scaled;
            cos2x <= x;
         end
      end
   end

endmodule
